// File: rtl/slice_subtractor16.sv
// Sequential A - B - bin subtractor resolving SLICE bits per clock with
// borrow-lookahead inside each slice and a registered borrow between slices.
module slice_subtractor16 #(
   parameter int WIDTH = 16,
   parameter int SLICE = 4
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             start_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             bin_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] diff_o,
   output logic             bout_o,
   output logic             ovf_o,
   output logic             zero_o
);

   localparam int NSLICE = WIDTH / SLICE;
   localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   opA_q, opA_d, opB_q, opB_d;
   logic [WIDTH-1:0]   diffInt_q, diffInt_d, diff_q, diff_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               borrow_q, borrow_d;
   logic               bout_q, bout_d, ovf_q, ovf_d, zero_q, zero_d;

   logic [SLICE-1:0]   sliceA, sliceB, gen, prop, sliceD;
   logic [SLICE:0]     br;
   logic [WIDTH-1:0]   diffFull;
   logic               term;

   // Each lookahead borrow is built as an OR of AND terms over the slice
   // inputs and the incoming borrow, so no borrow ripples bit to bit.
   always_comb begin
      sliceA = opA_q[idx_q*SLICE +: SLICE];
      sliceB = opB_q[idx_q*SLICE +: SLICE];
      gen    = ~sliceA & sliceB;
      prop   = ~(sliceA ^ sliceB);
      br     = '0;
      term   = 1'b0;
      br[0]  = borrow_q;
      for (int i = 0; i < SLICE; i++) begin
         term = borrow_q;
         for (int k = 0; k <= i; k++) term = term & prop[k];
         br[i+1] = term;
         for (int j = 0; j <= i; j++) begin
            term = gen[j];
            for (int k = j + 1; k <= i; k++) term = term & prop[k];
            br[i+1] = br[i+1] | term;
         end
      end
      sliceD   = sliceA ^ sliceB ^ br[SLICE-1:0];
      diffFull = diffInt_q;
      diffFull[idx_q*SLICE +: SLICE] = sliceD;
   end

   // DONE accepts a new start exactly like IDLE to allow back-to-back operations.
   always_comb begin
      state_d   = state_q;
      opA_d     = opA_q;
      opB_d     = opB_q;
      diffInt_d = diffInt_q;
      idx_d     = idx_q;
      borrow_d  = borrow_q;
      diff_d    = diff_q;
      bout_d    = bout_q;
      ovf_d     = ovf_q;
      zero_d    = zero_q;
      case (state_q)
         IDLE, DONE: begin
            if (start_i) begin
               opA_d     = a_i;
               opB_d     = b_i;
               borrow_d  = bin_i;
               idx_d     = '0;
               diffInt_d = '0;
               state_d   = RUN;
            end else begin
               state_d   = IDLE;
            end
         end
         RUN: begin
            diffInt_d = diffFull;
            borrow_d  = br[SLICE];
            idx_d     = idx_q + 1'b1;
            if (idx_q == IDX_W'(NSLICE - 1)) begin
               state_d = DONE;
               diff_d  = diffFull;
               bout_d  = br[SLICE];
               ovf_d   = (opA_q[WIDTH-1] ^ opB_q[WIDTH-1]) & (diffFull[WIDTH-1] ^ opA_q[WIDTH-1]);
               zero_d  = (diffFull == '0);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q   <= IDLE;
         opA_q     <= '0;
         opB_q     <= '0;
         diffInt_q <= '0;
         idx_q     <= '0;
         borrow_q  <= 1'b0;
         diff_q    <= '0;
         bout_q    <= 1'b0;
         ovf_q     <= 1'b0;
         zero_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         opA_q     <= opA_d;
         opB_q     <= opB_d;
         diffInt_q <= diffInt_d;
         idx_q     <= idx_d;
         borrow_q  <= borrow_d;
         diff_q    <= diff_d;
         bout_q    <= bout_d;
         ovf_q     <= ovf_d;
         zero_q    <= zero_d;
      end
   end

   assign busy_o = (state_q == RUN);
   assign done_o = (state_q == DONE);
   assign diff_o = diff_q;
   assign bout_o = bout_q;
   assign ovf_o  = ovf_q;
   assign zero_o = zero_q;

endmodule
